// File: rtl/mlp_pkg.sv
// Shared types and constants for the MLP dense-layer engine: FSM states,
// piecewise-sigmoid breakpoints/offsets and width helpers.
package mlp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_X,
        BIAS,
        MAC,
        ACT,
        OUT
    } state_t;

    localparam int SIG_BP_HI   = 6144;
    localparam int SIG_BP_LO   = 3072;
    localparam int SIG_OFF_LO  = 8;
    localparam int SIG_OFF_MID = 128;
    localparam int SIG_OFF_HI  = 224;
    localparam int SIG_MAX     = 255;

    // Clamp a sign-extended accumulator to the activation's 16-bit input range.
    function automatic logic signed [15:0] sat16(input logic signed [63:0] v);
        if (v > 64'sd32767)
            return 16'sh7FFF;
        else if (v < -64'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    function automatic int cfg_aw(input int n_in, input int n_out);
        return $clog2(n_in * n_out + n_out);
    endfunction

    function automatic int idx_aw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mlp_dense_layer_if.sv
// Config, input-stream, output-stream and argmax signals of one dense layer.
// slave = layer side, master = driver/upstream side.
interface mlp_dense_layer_if #(
    parameter int N_IN  = 784,
    parameter int N_OUT = 300,
    parameter int DW    = 8
);
    import mlp_pkg::*;

    localparam int CAW = cfg_aw(N_IN, N_OUT);
    localparam int OAW = idx_aw(N_OUT);

    logic           cfg_we;
    logic [CAW-1:0] cfg_addr;
    logic [DW-1:0]  cfg_wdata;
    logic           cfg_err;
    logic           in_valid;
    logic [DW-1:0]  in_data;
    logic           in_ready;
    logic           out_valid;
    logic [DW-1:0]  out_data;
    logic           out_last;
    logic           out_ready;
    logic           busy;
    logic           am_valid;
    logic [OAW-1:0] am_index;

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, in_valid, in_data, out_ready,
        output cfg_err, in_ready, out_valid, out_data, out_last, busy,
               am_valid, am_index
    );

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, in_valid, in_data, out_ready,
        input  cfg_err, in_ready, out_valid, out_data, out_last, busy,
               am_valid, am_index
    );

endinterface

// File: rtl/mlp_sigmoid_pw.sv
// Combinational five-segment piecewise-linear sigmoid: signed 16-bit z to
// unsigned 8-bit activation. Shared by every layer instance.
module mlp_sigmoid_pw
    import mlp_pkg::*;
(
    input  logic signed [15:0] i_z,
    output logic [7:0]         o_y
);

    int w_z;
    int w_t;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_z = int'(i_z);
        w_t = SIG_MAX;
        if (w_z < -SIG_BP_HI)
            w_t = 0;
        else if (w_z < -SIG_BP_LO)
            w_t = SIG_OFF_LO + ((w_z + SIG_BP_HI) >>> 7);
        else if (w_z < SIG_BP_LO)
            w_t = SIG_OFF_MID + (w_z >>> 5);
        else if (w_z < SIG_BP_HI)
            w_t = SIG_OFF_HI + ((w_z - SIG_BP_LO) >>> 7);
        o_y = 8'(w_t);
    end

endmodule

// File: rtl/mlp_dense_layer.sv
// Fully-connected layer engine: one MAC per cycle over RAM-held weights.
// Optional argmax tracker enabled by defining MLP_ARGMAX_EN.
module mlp_dense_layer
    import mlp_pkg::*;
#(
    parameter int N_IN       = 784,
    parameter int N_OUT      = 300,
    parameter int DW         = 8,
    parameter int ACC_W      = 32,
    parameter int BIAS_SHIFT = 6,
    parameter int Z_SHIFT    = 0
) (
    input logic              clk,
    input logic              reset_n,
    mlp_dense_layer_if.slave bus
);

    localparam int N_W = N_IN * N_OUT;
    localparam int CAW = cfg_aw(N_IN, N_OUT);
    localparam int OAW = idx_aw(N_OUT);
    localparam int IW  = idx_aw(N_IN);

    state_t r_state;
    state_t w_next;

    logic [IW-1:0]           r_i;
    logic [OAW-1:0]          r_o;
    logic [CAW-1:0]          r_waddr;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_out_valid;
    logic                    r_out_last;
    logic [DW-1:0]           r_out_data;
    logic                    r_cfg_err;

    logic [DW-1:0]           r_x     [N_IN];
    logic signed [DW-1:0]    r_w_ram [N_W];
    logic signed [DW-1:0]    r_bias  [N_OUT];
    logic signed [DW-1:0]    r_w_rd;

    logic                    w_in_hs;
    logic                    w_out_hs;
    logic                    w_last_i;
    logic                    w_last_o;
    logic                    w_cfg_ok;
    logic                    w_cfg_is_w;
    logic signed [2*DW:0]    w_prod;
    logic signed [ACC_W-1:0] w_bias_acc;
    logic signed [ACC_W-1:0] w_z_acc;
    logic signed [15:0]      w_z;
    logic [7:0]              w_y;

    assign bus.in_ready  = (r_state == IDLE) || (r_state == LOAD_X);
    assign bus.busy      = (r_state != IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.cfg_err   = r_cfg_err;

    assign w_in_hs    = bus.in_valid && bus.in_ready;
    assign w_out_hs   = r_out_valid && bus.out_ready;
    assign w_last_i   = (r_i == IW'(N_IN - 1));
    assign w_last_o   = (r_o == OAW'(N_OUT - 1));
    assign w_cfg_is_w = int'(bus.cfg_addr) < N_W;
    assign w_cfg_ok   = bus.cfg_we && (r_state == IDLE) && (int'(bus.cfg_addr) < N_W + N_OUT);

    // x is unsigned, so widen with a zero MSB before the signed multiply.
    assign w_prod     = $signed({1'b0, r_x[r_i]}) * r_w_rd;
    assign w_bias_acc = ACC_W'(r_bias[r_o]) <<< BIAS_SHIFT;
    assign w_z_acc    = r_acc >>> Z_SHIFT;
    assign w_z        = sat16(64'(w_z_acc));

    mlp_sigmoid_pw u_sigmoid (
        .i_z (w_z),
        .o_y (w_y)
    );

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_in_hs) w_next = LOAD_X;
            LOAD_X:  if (w_in_hs && w_last_i) w_next = BIAS;
            BIAS:    w_next = MAC;
            MAC:     if (w_last_i) w_next = ACT;
            ACT:     w_next = OUT;
            OUT:     if (w_out_hs) w_next = w_last_o ? IDLE : BIAS;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i         <= '0;
            r_o         <= '0;
            r_waddr     <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err <= bus.cfg_we && !w_cfg_ok;
            unique case (r_state)
                IDLE, LOAD_X: begin
                    if (w_in_hs)
                        r_i <= w_last_i ? '0 : r_i + 1'b1;
                end
                BIAS: begin
                    r_acc   <= w_bias_acc;
                    r_waddr <= r_waddr + 1'b1;
                end
                MAC: begin
                    r_acc <= r_acc + ACC_W'(w_prod);
                    r_i   <= w_last_i ? '0 : r_i + 1'b1;
                    if (!w_last_i)
                        r_waddr <= r_waddr + 1'b1;
                end
                ACT: begin
                    r_out_data  <= DW'(w_y);
                    r_out_valid <= 1'b1;
                    r_out_last  <= w_last_o;
                end
                OUT: begin
                    if (w_out_hs) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (w_last_o) begin
                            r_o     <= '0;
                            r_waddr <= '0;
                        end else begin
                            r_o <= r_o + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: storage arrays have no reset so they map onto RAM; contents survive reset_n.
    always_ff @(posedge clk) begin
        if (w_cfg_ok) begin
            if (w_cfg_is_w)
                r_w_ram[bus.cfg_addr] <= bus.cfg_wdata;
            else
                r_bias[OAW'(int'(bus.cfg_addr) - N_W)] <= bus.cfg_wdata;
        end
        if (w_in_hs)
            r_x[r_i] <= bus.in_data;
        // Read runs one step ahead of the MAC so weight i is ready when x[i] is used.
        if ((r_state == BIAS) || ((r_state == MAC) && !w_last_i))
            r_w_rd <= r_w_ram[r_waddr];
    end

`ifdef MLP_ARGMAX_EN
    logic [DW-1:0]  r_am_max;
    logic [OAW-1:0] r_am_idx;
    logic [OAW-1:0] r_am_index;
    logic           r_am_valid;
    logic           w_am_take;

    // Strict compare keeps the lowest index on ties.
    assign w_am_take = (r_o == '0) || (r_out_data > r_am_max);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_am_max   <= '0;
            r_am_idx   <= '0;
            r_am_index <= '0;
            r_am_valid <= 1'b0;
        end else begin
            r_am_valid <= 1'b0;
            if (w_out_hs) begin
                if (w_am_take) begin
                    r_am_max <= r_out_data;
                    r_am_idx <= r_o;
                end
                if (w_last_o) begin
                    r_am_valid <= 1'b1;
                    r_am_index <= w_am_take ? r_o : r_am_idx;
                end
            end
        end
    end

    assign bus.am_valid = r_am_valid;
    assign bus.am_index = r_am_index;
`else
    assign bus.am_valid = 1'b0;
    assign bus.am_index = '0;
`endif

endmodule

// File: tb/tb_mlp_dense_layer.sv
// Scoreboard bench for mlp_dense_layer (N_IN=4, N_OUT=3): directed cases plus
// randomized vectors checked against an arithmetic reference model.
module tb_mlp_dense_layer;

    localparam int N_IN       = 4;
    localparam int N_OUT      = 3;
    localparam int DW         = 8;
    localparam int BIAS_SHIFT = 6;
    localparam int Z_SHIFT    = 0;
    localparam int N_W        = N_IN * N_OUT;
    localparam int CAW        = 4;

    typedef struct {
        int data;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    mlp_dense_layer_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW)) bus ();

    mlp_dense_layer #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .ACC_W(32),
        .BIAS_SHIFT(BIAS_SHIFT), .Z_SHIFT(Z_SHIFT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    exp_t exp_q[$];
    int   am_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   m_w[N_W];
    int   m_b[N_OUT];
    int   cur_x[N_IN];
    int   rdy_mode = 0;
    logic rdy_force = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: y = sigmoid(sat16((bias*2^BIAS_SHIFT + sum x*w) / 2^Z_SHIFT)).
    function automatic int model_y(input int o);
        longint acc;
        int     z;
        acc = longint'(m_b[o]) * (longint'(1) << BIAS_SHIFT);
        for (int i = 0; i < N_IN; i++)
            acc += longint'(cur_x[i]) * longint'(m_w[o * N_IN + i]);
        acc = acc >>> Z_SHIFT;
        if (acc > 32767)       z = 32767;
        else if (acc < -32768) z = -32768;
        else                   z = int'(acc);
        if (z < -6144) return 0;
        if (z < -3072) return 8 + (z + 6144) / 128;
        if (z < 3072)  return 128 + (z + 32768) / 32 - 1024;
        if (z < 6144)  return 224 + (z - 3072) / 128;
        return 255;
    endfunction

    task automatic push_expect();
        exp_t e;
        int   best = -1;
        int   bi = 0;
        for (int o = 0; o < N_OUT; o++) begin
            e.data = model_y(o);
            e.last = (o == N_OUT - 1);
            exp_q.push_back(e);
            if (e.data > best) begin
                best = e.data;
                bi = o;
            end
        end
`ifdef MLP_ARGMAX_EN
        am_q.push_back(bi);
`endif
    endtask

    task automatic cfg_write(input int addr, input int data, input bit exp_err);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = CAW'(addr);
        bus.cfg_wdata = 8'(data);
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        check("cfg_err", int'(bus.cfg_err), int'(exp_err));
        if (!exp_err) begin
            if (addr < N_W) m_w[addr] = ((data & 255) ^ 128) - 128;
            else            m_b[addr - N_W] = ((data & 255) ^ 128) - 128;
        end
    endtask

    task automatic set_weights(input int wv);
        for (int a = 0; a < N_W; a++) cfg_write(a, wv, 1'b0);
    endtask

    task automatic set_biases(input int b0, input int b1, input int b2);
        cfg_write(N_W + 0, b0, 1'b0);
        cfg_write(N_W + 1, b1, 1'b0);
        cfg_write(N_W + 2, b2, 1'b0);
    endtask

    task automatic set_x(input int x0, input int x1, input int x2, input int x3);
        cur_x[0] = x0; cur_x[1] = x1; cur_x[2] = x2; cur_x[3] = x3;
    endtask

    task automatic send_vector(input bit push);
        int t;
        if (push) push_expect();
        for (int i = 0; i < N_IN; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(cur_x[i]);
            t = 0;
            while (!bus.in_ready && t < 300) begin
                @(posedge clk); #1;
                t++;
            end
            if (t >= 300) check("in_ready timeout", 0, 1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || bus.busy) && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 500) check("drain timeout", 0, 1);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    // Monitor: compare every accepted output against the scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected out_valid", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", int'(bus.out_data), mon_e.data);
                    check("out_last", int'(bus.out_last), int'(mon_e.last));
                end
`ifndef MLP_ARGMAX_EN
                check("am_valid off", int'(bus.am_valid), 0);
                check("am_index off", int'(bus.am_index), 0);
`endif
            end
`ifdef MLP_ARGMAX_EN
            if (bus.am_valid) begin
                if (am_q.size() == 0) check("unexpected am_valid", 1, 0);
                else                  check("am_index", int'(bus.am_index), am_q.pop_front());
            end
`endif
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = rdy_force;
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int d;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;

        // Reset and idle.
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("reset in_ready", int'(bus.in_ready), 1);
        check("reset out_valid", int'(bus.out_valid), 0);
        check("reset busy", int'(bus.busy), 0);
        check("reset am_valid", int'(bus.am_valid), 0);
        check("reset out_data", int'(bus.out_data), 0);
        check("reset cfg_err", int'(bus.cfg_err), 0);

        // Unit weights, zero bias, with latency from BIAS entry.
        set_weights(1);
        set_biases(0, 0, 0);
        set_x(10, 20, 30, 40);
        send_vector(1'b1);
        k = 0;
        while (!bus.out_valid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("latency", k, N_IN + 2);
        wait_idle();

        // Backpressure: output held stable for 5 cycles.
        rdy_force = 1'b0;
        rdy_mode  = 2;
        repeat (2) begin @(posedge clk); #1; end
        set_x(5, 90, 200, 17);
        send_vector(1'b1);
        k = 0;
        while (!bus.out_valid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        d = int'(bus.out_data);
        check("held first value", d, model_y(0));
        repeat (5) begin
            @(posedge clk); #1;
            check("hold out_valid", int'(bus.out_valid), 1);
            check("hold out_data", int'(bus.out_data), d);
        end
        rdy_force = 1'b1;
        wait_idle();
        rdy_mode = 0;

        // Config attempt during MAC, then out-of-range and top in-range addresses.
        set_x(10, 20, 30, 40);
        send_vector(1'b1);
        @(posedge clk); #1;
        cfg_write(0, 99, 1'b1);
        wait_idle();
        cfg_write(15, 5, 1'b1);
        cfg_write(14, 0, 1'b0);

        // Saturation at both ends.
        set_weights(127);
        set_x(255, 255, 255, 255);
        send_vector(1'b1);
        wait_idle();
        set_weights(-128);
        send_vector(1'b1);
        wait_idle();

        // Bias-only outputs exercise three sigmoid segments and argmax.
        set_weights(0);
        set_biases(0, 64, -64);
        set_x(1, 2, 3, 4);
        send_vector(1'b1);
        wait_idle();

        // Reset mid-MAC, then rerun on retained RAM.
        set_weights(1);
        set_biases(0, 0, 0);
        set_x(10, 20, 30, 40);
        send_vector(1'b0);
        repeat (2) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        #1;
        check("mid reset in_ready", int'(bus.in_ready), 1);
        check("mid reset busy", int'(bus.busy), 0);
        check("mid reset out_valid", int'(bus.out_valid), 0);
        check("mid reset out_last", int'(bus.out_last), 0);
        check("mid reset out_data", int'(bus.out_data), 0);
        check("mid reset am_valid", int'(bus.am_valid), 0);
        check("mid reset am_index", int'(bus.am_index), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        send_vector(1'b1);
        wait_idle();

        // Randomized weights/biases/inputs with random backpressure.
        rdy_mode = 1;
        for (int v = 0; v < 24; v++) begin
            if (v % 4 == 0) begin
                wait_idle();
                for (int a = 0; a < N_W; a++)
                    cfg_write(a, (v % 8 == 0) ? int'($urandom_range(0, 255))
                                              : int'($urandom_range(0, 31)) - 16, 1'b0);
                for (int o = 0; o < N_OUT; o++)
                    cfg_write(N_W + o, int'($urandom_range(0, 255)), 1'b0);
            end
            for (int i = 0; i < N_IN; i++) cur_x[i] = int'($urandom_range(0, 255));
            send_vector(1'b1);
        end
        wait_idle();
        rdy_mode = 0;

        check("scoreboard drained", exp_q.size(), 0);
        check("argmax drained", am_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
